// File: rtl/mgmt_hub.sv
// mgmt_hub: routes one outstanding management request to one of N_SLV slaves
// and returns the slave's ack/read data, with decode-miss and timeout errors.
module mgmt_hub #(
    parameter int                  N_SLV    = 5,
    parameter logic [32*N_SLV-1:0] SLV_BASE = {N_SLV{32'h0000_0000}},
    parameter logic [32*N_SLV-1:0] SLV_MASK = {N_SLV{32'hFFFF_F000}},
    parameter int                  TIMEOUT  = 255,
    parameter logic [31:0]         ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                 sys_clk,
    input  logic                 sys_rstn,
    input  logic                 mgmt_req,
    input  logic [31:0]          mgmt_adr,
    input  logic                 mgmt_rwn,
    input  logic [1:0]           mgmt_wen,
    input  logic [31:0]          mgmt_txd,
    output logic                 mgmt_ack,
    output logic                 mgmt_rxe,
    output logic [31:0]          mgmt_rxd,
    output logic                 mgmt_err,
    output logic                 mgmt_busy,
    output logic                 proto_err,
    output logic [N_SLV-1:0]     s_req,
    output logic [31:0]          s_adr,
    output logic                 s_rwn,
    output logic [1:0]           s_wen,
    output logic [31:0]          s_txd,
    input  logic [N_SLV-1:0]     s_ack,
    input  logic [N_SLV-1:0]     s_rxe,
    input  logic [32*N_SLV-1:0]  s_rxd
);

    localparam int SW = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_ACK = 2'd1,
        WAIT_RXE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [SW-1:0]    sel_r;
    logic [TW-1:0]    tmo_cnt_r;
    logic [N_SLV-1:0] hit_vec_s, req_vec_s;
    logic             hit_s;
    logic [SW-1:0]    hit_idx_s;
    logic             own_ack_s, own_rxe_s, stray_s;
    logic [31:0]      own_rxd_s, rxd_val_s;
    logic             start_s, ack_s, rxe_s, err_s, drop_s, tmo_hit_s;

    // Address decode; scanning downward lets the lowest matching index win
    always_comb begin
        hit_vec_s = '0;
        hit_idx_s = '0;
        for (int i = 0; i < N_SLV; i++) begin
            hit_vec_s[i] = ((mgmt_adr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
        end
        for (int i = N_SLV - 1; i >= 0; i--) begin
            hit_idx_s = hit_vec_s[i] ? SW'(i) : hit_idx_s;
        end
        hit_s = |hit_vec_s;
    end

    // Split slave handshakes into the selected slave's and strays (anything else, or anything while idle)
    always_comb begin
        own_ack_s = 1'b0;
        own_rxe_s = 1'b0;
        own_rxd_s = '0;
        stray_s   = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if ((SW'(i) == sel_r) && (state_r != IDLE)) begin
                own_ack_s = s_ack[i];
                own_rxe_s = s_rxe[i];
                own_rxd_s = s_rxd[32*i +: 32];
            end else begin
                stray_s = stray_s | s_ack[i] | s_rxe[i];
            end
        end
    end

    // Next-state and response decisions
    always_comb begin
        state_s   = state_r;
        start_s   = 1'b0;
        ack_s     = 1'b0;
        rxe_s     = 1'b0;
        err_s     = 1'b0;
        drop_s    = 1'b0;
        rxd_val_s = own_rxd_s;
        tmo_hit_s = (TIMEOUT != 0) && (tmo_cnt_r == TW'(TIMEOUT));
        case (state_r)
            IDLE: begin
                if (mgmt_req && hit_s) begin
                    start_s = 1'b1;
                    state_s = WAIT_ACK;
                end else if (mgmt_req) begin
                    ack_s     = 1'b1;
                    err_s     = 1'b1;
                    rxe_s     = mgmt_rwn;
                    rxd_val_s = ERR_DATA;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT_ACK: begin
                drop_s = mgmt_req;
                if (own_ack_s) begin
                    ack_s = 1'b1;
                    if (s_rwn && !own_rxe_s) begin
                        state_s = WAIT_RXE;
                    end else begin
                        rxe_s   = s_rwn;
                        state_s = IDLE;
                    end
                end else if (tmo_hit_s) begin
                    ack_s     = 1'b1;
                    err_s     = 1'b1;
                    rxe_s     = s_rwn;
                    rxd_val_s = ERR_DATA;
                    state_s   = IDLE;
                end else begin
                    state_s = WAIT_ACK;
                end
            end
            WAIT_RXE: begin
                drop_s = mgmt_req;
                if (own_rxe_s) begin
                    rxe_s   = 1'b1;
                    state_s = IDLE;
                end else if (tmo_hit_s) begin
                    rxe_s     = 1'b1;
                    err_s     = 1'b1;
                    rxd_val_s = ERR_DATA;
                    state_s   = IDLE;
                end else begin
                    state_s = WAIT_RXE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // One-hot slave request for the decoded winner
    always_comb begin
        req_vec_s = '0;
        for (int i = 0; i < N_SLV; i++) begin
            req_vec_s[i] = start_s && (hit_idx_s == SW'(i));
        end
    end

    // State register
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Registered outputs, latched request fields and timeout counter
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sel_r     <= '0;
            tmo_cnt_r <= '0;
            s_req     <= '0;
            s_adr     <= 32'h0000_0000;
            s_rwn     <= 1'b1;
            s_wen     <= 2'b00;
            s_txd     <= 32'h0000_0000;
            mgmt_ack  <= 1'b0;
            mgmt_rxe  <= 1'b0;
            mgmt_err  <= 1'b0;
            mgmt_rxd  <= 32'h0000_0000;
            mgmt_busy <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            s_req     <= req_vec_s;
            mgmt_ack  <= ack_s;
            mgmt_rxe  <= rxe_s;
            mgmt_err  <= err_s;
            mgmt_busy <= (state_s != IDLE);
            proto_err <= proto_err | stray_s | drop_s;
            if (rxe_s) begin
                mgmt_rxd <= rxd_val_s;
            end else begin
                mgmt_rxd <= mgmt_rxd;
            end
            if (start_s) begin
                sel_r <= hit_idx_s;
                s_adr <= mgmt_adr;
                s_rwn <= mgmt_rwn;
                s_wen <= mgmt_wen;
                s_txd <= mgmt_txd;
            end else begin
                sel_r <= sel_r;
            end
            // Counter restarts on every state change, so entering either wait state sees zero
            if ((state_r != IDLE) && (state_s == state_r)) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end else begin
                tmo_cnt_r <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mgmt_hub.sv
// Directed bench for mgmt_hub: stimulus pushes expected responses into a queue,
// a negedge monitor pops and compares whenever the hub presents ack/rxe/err.
module tb_mgmt_hub;

    logic         sys_clk;
    logic         sys_rstn;
    logic         mgmt_req;
    logic [31:0]  mgmt_adr;
    logic         mgmt_rwn;
    logic [1:0]   mgmt_wen;
    logic [31:0]  mgmt_txd;
    logic         mgmt_ack;
    logic         mgmt_rxe;
    logic [31:0]  mgmt_rxd;
    logic         mgmt_err;
    logic         mgmt_busy;
    logic         proto_err;
    logic [3:0]   s_req;
    logic [31:0]  s_adr;
    logic         s_rwn;
    logic [1:0]   s_wen;
    logic [31:0]  s_txd;
    logic [3:0]   s_ack;
    logic [3:0]   s_rxe;
    logic [127:0] s_rxd;

    typedef struct {
        logic        ack;
        logic        rxe;
        logic        err;
        logic [31:0] rxd;
        int          cyc;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   c0;

    // Slave 3 overlaps slaves 0..2 so lower indices must win there
    mgmt_hub #(
        .N_SLV    (4),
        .SLV_BASE ({32'h0000_0000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000}),
        .SLV_MASK ({32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000}),
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rstn  (sys_rstn),
        .mgmt_req  (mgmt_req),
        .mgmt_adr  (mgmt_adr),
        .mgmt_rwn  (mgmt_rwn),
        .mgmt_wen  (mgmt_wen),
        .mgmt_txd  (mgmt_txd),
        .mgmt_ack  (mgmt_ack),
        .mgmt_rxe  (mgmt_rxe),
        .mgmt_rxd  (mgmt_rxd),
        .mgmt_err  (mgmt_err),
        .mgmt_busy (mgmt_busy),
        .proto_err (proto_err),
        .s_req     (s_req),
        .s_adr     (s_adr),
        .s_rwn     (s_rwn),
        .s_wen     (s_wen),
        .s_txd     (s_txd),
        .s_ack     (s_ack),
        .s_rxe     (s_rxe),
        .s_rxd     (s_rxd)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_rsp(input logic ack, input logic rxe, input logic err,
                              input logic [31:0] rxd, input int at);
        rsp_t r;
        r.ack = ack;
        r.rxe = rxe;
        r.err = err;
        r.rxd = rxd;
        r.cyc = at;
        exp_q.push_back(r);
    endtask

    task automatic tick();
        @(negedge sys_clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge sys_clk);
    endtask

    task automatic issue(input logic [31:0] adr, input logic rwn, input logic [1:0] wen,
                         input logic [31:0] txd);
        mgmt_req = 1'b1;
        mgmt_adr = adr;
        mgmt_rwn = rwn;
        mgmt_wen = wen;
        mgmt_txd = txd;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctl"}, 64'({s_req, mgmt_ack, mgmt_rxe, mgmt_err, mgmt_busy,
                                  proto_err, s_rwn, s_wen}), 64'(12'h004));
        check({tag, "_rxd_adr"}, {mgmt_rxd, s_adr}, 64'd0);
        check({tag, "_txd"}, 64'(s_txd), 64'd0);
    endtask

    // Scoreboard monitor: every presented response must match the oldest expectation
    always @(negedge sys_clk) begin
        if (mgmt_ack || mgmt_rxe || mgmt_err) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got ack=%0b rxe=%0b err=%0b at cycle %0d, required no response",
                         mgmt_ack, mgmt_rxe, mgmt_err, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_cycle", 64'(cyc), 64'(mon_e.cyc));
                check("rsp_flags", 64'({mgmt_ack, mgmt_rxe, mgmt_err}),
                      64'({mon_e.ack, mon_e.rxe, mon_e.err}));
                if (mon_e.rxe) check("rsp_rxd", 64'(mgmt_rxd), 64'(mon_e.rxd));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion within 100000 time units");
        $fatal(1);
    end

    initial begin
        sys_rstn = 1'b0;
        mgmt_req = 1'b0;
        mgmt_adr = 32'h0000_0000;
        mgmt_rwn = 1'b0;
        mgmt_wen = 2'b00;
        mgmt_txd = 32'h0000_0000;
        s_ack    = 4'b0000;
        s_rxe    = 4'b0000;
        s_rxd    = 128'd0;
        ticks(2);
        check_reset_vals("por");
        sys_rstn = 1'b1;
        tick();

        // Read slave 2 (also hits slave 3): ack at +2, data at +5
        c0 = cyc;
        issue(32'h0000_2004, 1'b1, 2'b00, 32'h0000_0000);
        tick();
        mgmt_req = 1'b0;
        check("t1_sreq", 64'(s_req), 64'(4'b0100));
        check("t1_busy", 64'(mgmt_busy), 64'd1);
        check("t1_sadr", 64'(s_adr), 64'(32'h0000_2004));
        tick();
        check("t1_sreq_once", 64'(s_req), 64'd0);
        s_ack[2] = 1'b1;
        expect_rsp(1'b1, 1'b0, 1'b0, 32'h0, c0 + 3);
        tick();
        s_ack = 4'b0000;
        check("t1_busy_rxe", 64'(mgmt_busy), 64'd1);
        ticks(2);
        s_rxe[2] = 1'b1;
        s_rxd[95:64] = 32'h1234_5678;
        expect_rsp(1'b0, 1'b1, 1'b0, 32'h1234_5678, c0 + 6);
        tick();
        s_rxe = 4'b0000;
        check("t1_idle", 64'(mgmt_busy), 64'd0);

        // Unmapped read: immediate error response, no slave request
        tick();
        c0 = cyc;
        issue(32'hF000_0000, 1'b1, 2'b00, 32'h0000_0000);
        expect_rsp(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, c0 + 1);
        tick();
        mgmt_req = 1'b0;
        check("t2_no_sreq", 64'(s_req), 64'd0);
        check("t2_busy", 64'(mgmt_busy), 64'd0);
        tick();
        check("t2_no_sreq_late", 64'(s_req), 64'd0);

        // Write to slave 1 that is never acked: timeout after 8 cycles in WAIT_ACK
        c0 = cyc;
        issue(32'h0000_1010, 1'b0, 2'b10, 32'hCAFE_0001);
        expect_rsp(1'b1, 1'b0, 1'b1, 32'h0, c0 + 10);
        tick();
        mgmt_req = 1'b0;
        check("t3_sreq", 64'(s_req), 64'(4'b0010));
        check("t3_fields", {s_txd, 29'd0, s_rwn, s_wen}, {32'hCAFE_0001, 29'd0, 1'b0, 2'b10});
        ticks(8);
        check("t3_busy_before_tmo", 64'(mgmt_busy), 64'd1);
        tick();
        check("t3_idle_after_tmo", 64'(mgmt_busy), 64'd0);

        // Read slave 0 with ack and rxe in the same cycle
        c0 = cyc;
        issue(32'h0000_0010, 1'b1, 2'b00, 32'h0000_0000);
        tick();
        mgmt_req = 1'b0;
        check("t4_sreq", 64'(s_req), 64'(4'b0001));
        tick();
        s_ack[0] = 1'b1;
        s_rxe[0] = 1'b1;
        s_rxd[31:0] = 32'hA5A5_5A5A;
        expect_rsp(1'b1, 1'b1, 1'b0, 32'hA5A5_5A5A, c0 + 3);
        tick();
        s_ack = 4'b0000;
        s_rxe = 4'b0000;
        s_rxd[31:0] = 32'h0000_0000;
        check("t4_busy_next", 64'(mgmt_busy), 64'd0);
        tick();
        check("t4_rxd_hold", 64'(mgmt_rxd), 64'(32'hA5A5_5A5A));

        // Read slave 1, acked but data never arrives: timeout in WAIT_RXE
        c0 = cyc;
        issue(32'h0000_1020, 1'b1, 2'b00, 32'h0000_0000);
        tick();
        mgmt_req = 1'b0;
        tick();
        s_ack[1] = 1'b1;
        expect_rsp(1'b1, 1'b0, 1'b0, 32'h0, c0 + 3);
        expect_rsp(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, c0 + 12);
        tick();
        s_ack = 4'b0000;
        ticks(8);
        check("t5_busy_before_tmo", 64'(mgmt_busy), 64'd1);
        tick();
        check("t5_idle_after_tmo", 64'(mgmt_busy), 64'd0);
        check("t5_no_proto_err", 64'(proto_err), 64'd0);

        // Stray ack from slave 3, then a request while busy, during a write to slave 0
        c0 = cyc;
        issue(32'h0000_0100, 1'b0, 2'b11, 32'h0000_0055);
        tick();
        mgmt_req = 1'b0;
        check("t6_sreq", 64'(s_req), 64'(4'b0001));
        s_ack[3] = 1'b1;
        tick();
        s_ack = 4'b0000;
        check("t6_proto_stray", 64'(proto_err), 64'd1);
        issue(32'h0000_2000, 1'b0, 2'b01, 32'h0000_0077);
        tick();
        mgmt_req = 1'b0;
        check("t6_dropped_no_sreq", 64'(s_req), 64'd0);
        check("t6_fields_kept", {s_adr, s_txd}, {32'h0000_0100, 32'h0000_0055});
        s_ack[0] = 1'b1;
        expect_rsp(1'b1, 1'b0, 1'b0, 32'h0, c0 + 4);
        tick();
        s_ack = 4'b0000;
        check("t6_idle", 64'(mgmt_busy), 64'd0);
        tick();
        check("t6_proto_sticky", 64'({s_req, proto_err}), 64'(5'b0000_1));

        // Reset pulsed while waiting for read data; late data must be ignored
        c0 = cyc;
        issue(32'h0000_2008, 1'b1, 2'b00, 32'h0000_0000);
        tick();
        mgmt_req = 1'b0;
        tick();
        s_ack[2] = 1'b1;
        expect_rsp(1'b1, 1'b0, 1'b0, 32'h0, c0 + 3);
        tick();
        s_ack = 4'b0000;
        check("t7_in_wait_rxe", 64'(mgmt_busy), 64'd1);
        #2;
        sys_rstn = 1'b0;
        #1;
        check_reset_vals("t7_midrst");
        tick();
        sys_rstn = 1'b1;
        s_rxe[2] = 1'b1;
        s_rxd[95:64] = 32'h7777_7777;
        tick();
        s_rxe = 4'b0000;
        check("t7_late_rxe_flagged", 64'(proto_err), 64'd1);
        ticks(2);

        // New read to slave 3 after reset
        c0 = cyc;
        issue(32'h0000_3000, 1'b1, 2'b00, 32'h0000_0000);
        tick();
        mgmt_req = 1'b0;
        check("t8_sreq", 64'(s_req), 64'(4'b1000));
        tick();
        s_ack[3] = 1'b1;
        expect_rsp(1'b1, 1'b0, 1'b0, 32'h0, c0 + 3);
        tick();
        s_ack = 4'b0000;
        tick();
        s_rxe[3] = 1'b1;
        s_rxd[127:96] = 32'h0BAD_F00D;
        expect_rsp(1'b0, 1'b1, 1'b0, 32'h0BAD_F00D, c0 + 5);
        tick();
        s_rxe = 4'b0000;
        check("t8_idle", 64'(mgmt_busy), 64'd0);

        ticks(3);
        check("all_rsp_seen", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mgmt_hub.md
MGMT_HUB -- requirements
Module: mgmt_hub

Interface
REQ-001 SHALL have parameter N_SLV, default 5: number of management slaves (1..16).
REQ-002 SHALL have parameter SLV_BASE, default {N_SLV x 32'h0}: packed per-slave base addresses; slave i occupies bits [32i+31:32i].
REQ-003 SHALL have parameter SLV_MASK, default {N_SLV x 32'hFFFF_F000}: packed per-slave decode masks.
REQ-004 SHALL have parameter TIMEOUT, default 255: cycles to wait for a slave response; 0 disables the timeout.
REQ-005 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF: read data returned on any error.
REQ-006 SHALL use one clock and an asynchronous active-low reset.
REQ-007 SHALL have port sys_clk  in  1  system clock.
REQ-008 SHALL have port sys_rstn  in  1  async active-low reset.
REQ-009 SHALL have port mgmt_req  in  1  master request pulse.
REQ-010 SHALL have port mgmt_adr  in  32  request address.
REQ-011 SHALL have port mgmt_rwn  in  1  1=read, 0=write.
REQ-012 SHALL have port mgmt_wen  in  2  write enables.
REQ-013 SHALL have port mgmt_txd  in  32  write data.
REQ-014 SHALL have port mgmt_ack  out  1  request-accepted pulse.
REQ-015 SHALL have port mgmt_rxe  out  1  read-data-valid pulse.
REQ-016 SHALL have port mgmt_rxd  out  32  read data.
REQ-017 SHALL have port mgmt_err  out  1  error pulse, coincident with the error ack.
REQ-018 SHALL have port mgmt_busy  out  1  hub is not in IDLE.
REQ-019 SHALL have port proto_err  out  1  sticky protocol violation flag.
REQ-020 SHALL have port s_req  out  N_SLV  per-slave request pulse.
REQ-021 SHALL have ports s_adr / s_rwn / s_wen / s_txd  out  32/1/2/32  latched request fields, broadcast to all slaves.
REQ-022 SHALL have port s_ack  in  N_SLV  per-slave ack pulse.
REQ-023 SHALL have port s_rxe  in  N_SLV  per-slave read-valid pulse.
REQ-024 SHALL have port s_rxd  in  32*N_SLV  per-slave read data.

Function
REQ-025 SHALL decode slave i as a hit when (mgmt_adr & SLV_MASK[i]) == SLV_BASE[i]; when several slaves hit, the lowest index SHALL win.
REQ-026 SHALL implement a state machine with states IDLE, WAIT_ACK, WAIT_RXE and no others.
REQ-027 SHALL, in IDLE on mgmt_req with a hit on slave k, latch adr/rwn/wen/txd and the select k, drive s_req[k]=1 for exactly one cycle on the next edge, and enter WAIT_ACK.
REQ-028 SHALL, in IDLE on mgmt_req with no hit, pulse mgmt_ack and mgmt_err one cycle later; for a read it SHALL also pulse mgmt_rxe with mgmt_rxd=ERR_DATA in that same cycle; the state SHALL remain IDLE.
REQ-029 SHALL, in WAIT_ACK on s_ack[k], pulse mgmt_ack one cycle later; a write SHALL then return to IDLE, and a read SHALL enter WAIT_RXE.
REQ-030 SHALL, when s_ack[k] and s_rxe[k] arrive in the same cycle for a read, pulse mgmt_ack and mgmt_rxe together one cycle later and return to IDLE.
REQ-031 SHALL, in WAIT_RXE on s_rxe[k], register s_rxd[k] into mgmt_rxd, pulse mgmt_rxe one cycle later, and return to IDLE.
REQ-032 SHALL hold mgmt_rxd at its last value when mgmt_rxe=0.
REQ-033 SHALL clear a timeout counter on entry to WAIT_ACK and on entry to WAIT_RXE, and increment it each cycle spent in either state.
REQ-034 SHALL, when the timeout counter reaches TIMEOUT (TIMEOUT != 0), pulse mgmt_err and the outstanding response(s) one cycle later: in WAIT_ACK, mgmt_ack, plus mgmt_rxe with mgmt_rxd=ERR_DATA for a read; in WAIT_RXE, mgmt_rxe with mgmt_rxd=ERR_DATA; the state SHALL then return to IDLE.
REQ-035 SHALL ignore s_ack or s_rxe from any slave other than k, or received while in IDLE, and SHALL set proto_err.
REQ-036 SHALL ignore mgmt_req while mgmt_busy=1 (the request is dropped) and SHALL set proto_err.
REQ-037 SHALL clear proto_err only by reset.
REQ-038 SHALL give a minimum round trip, from mgmt_req to mgmt_ack, of 3 cycles (request register, slave ack, response register).

Reset
REQ-039 SHALL, on sys_rstn=0, immediately force state=IDLE, s_req=0, mgmt_ack=0, mgmt_rxe=0, mgmt_err=0, mgmt_busy=0, proto_err=0, mgmt_rxd=0, s_adr/s_txd=0, s_rwn=1, s_wen=0, and timeout counter=0.
REQ-040 SHALL, when reset is asserted mid-transaction, abandon the transaction with no response pulse; after reset releases, the first mgmt_req SHALL be decoded normally.

Verification
REQ-041 SHALL cover: N_SLV=4, SLV_BASE[2]=32'h2000, read 32'h2004, slave 2 acks at +2 and sends rxe with 32'h1234_5678 at +5 -> s_req=4'b0100 for one cycle; mgmt_ack once; mgmt_rxe once with rxd=32'h1234_5678; mgmt_err=0.
REQ-042 SHALL cover: read of unmapped 32'hF000_0000 -> at +1, mgmt_ack=1, mgmt_rxe=1, mgmt_err=1, rxd=32'hDEAD_BEEF; no s_req asserted.
REQ-043 SHALL cover: TIMEOUT=8, write to slave 1, slave never acks -> mgmt_ack and mgmt_err together, 8 cycles after WAIT_ACK entry +1; state returns to IDLE.
REQ-044 SHALL cover: read with s_ack[0] and s_rxe[0] in the same cycle -> mgmt_ack and mgmt_rxe in the same cycle; mgmt_busy=0 on the following cycle.
REQ-045 SHALL cover: stray s_ack[3] during a transaction to slave 0, then a second mgmt_req while busy -> proto_err=1 and stays set; the slave-0 transaction completes normally; the second request produces no s_req.
REQ-046 SHALL cover: sys_rstn pulsed low during WAIT_RXE -> all outputs at reset values within the same cycle; no mgmt_rxe afterwards; a new read then completes.
